// File: rtl/micro_sequencer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : micro_sequencer_pkg
// Description : Shared definitions for the microprogram sequencer: state
//               encoding, next-address select codes and address defaults.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package micro_sequencer_pkg;

   // Default micro-address width and entry points
   localparam int USEQ_AW          = 5;
   localparam int USEQ_START_ADDR  = 0;
   localparam int USEQ_FETCH_ADDR  = 1;
   localparam int USEQ_STACK_DEPTH = 4;

   // Sequencer state, encoding is visible on the state output
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_WAIT = 2'b10,
      ST_HALT = 2'b11
   } useq_state_e;

   // Next-address select field of the microinstruction
   localparam logic [1:0] SEL_NEXT = 2'b00;
   localparam logic [1:0] SEL_MAP  = 2'b01;
   localparam logic [1:0] SEL_BRZ  = 2'b10;
   localparam logic [1:0] SEL_RET  = 2'b11;

endpackage : micro_sequencer_pkg
`default_nettype wire

// File: rtl/micro_sequencer_ret_stack.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : useq_ret_stack
// Description : LIFO of micro-return addresses. Push on full and pop on empty
//               are ignored here; the sequencer flags them. Push has priority
//               over pop. Only built when USEQ_CALL_STACK_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module useq_ret_stack #(
   parameter int AW    = 5,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_data,
   output logic [AW-1:0] top,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_ptr;
   logic [IW-1:0] w_wr_idx;
   logic [IW-1:0] w_rd_idx;

   assign full     = (r_ptr == PW'(DEPTH));
   assign empty    = (r_ptr == '0);
   // Pointer counts occupied entries: write slot is ptr, top of stack is ptr-1
   assign w_wr_idx = IW'(r_ptr);
   assign w_rd_idx = IW'(r_ptr - PW'(1));
   assign top      = r_mem[w_rd_idx];

   // Occupancy pointer: push wins over pop, overflow/underflow leave it alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (push && !full) begin
         r_ptr <= r_ptr + PW'(1);
      end else if (pop && !empty) begin
         r_ptr <= r_ptr - PW'(1);
      end
   end

   // Entry storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push && !full) begin
         r_mem[w_wr_idx] <= push_data;
      end
   end

endmodule : useq_ret_stack
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : micro_sequencer
// Description : Clocked microprogram sequencer. Owns the control address
//               register, selects NEXT/MAP/BRZ/RET successors and stalls on a
//               memory req/ack handshake. Define USEQ_CALL_STACK_EN to enable
//               micro-call/return through a return-address stack.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter int          AW          = USEQ_AW,
   parameter logic [AW-1:0] START_ADDR = AW'(USEQ_START_ADDR),
   parameter logic [AW-1:0] FETCH_ADDR = AW'(USEQ_FETCH_ADDR),
   parameter int          STACK_DEPTH = USEQ_STACK_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          z_flag,
   input  logic [AW-1:0] map_addr,
   input  logic [AW-1:0] ctl_next,
   input  logic [1:0]    ctl_sel,
   input  logic          ctl_call,
   input  logic          ctl_mem,
   input  logic          ctl_halt,
   input  logic          mem_ack,
   output logic [AW-1:0] car,
   output logic          mem_req,
   output logic          busy,
   output logic [1:0]    state,
   output logic          useq_err
);

   useq_state_e   r_state;
   useq_state_e   w_state_next;
   logic [AW-1:0] r_car;
   logic [AW-1:0] w_car_next;
   logic [AW-1:0] w_car_inc;
   logic [AW-1:0] w_adv_addr;
   logic          r_mem_req;
   logic          w_mem_req_next;
   logic          r_err;
   logic          w_err_next;
   logic          w_advance;
   logic          w_adv_err;

   // Sequential successor wraps at 2^AW
   assign w_car_inc = r_car + AW'(1);

`ifdef USEQ_CALL_STACK_EN
   logic          w_push_req;
   logic          w_pop_req;
   logic          w_stk_full;
   logic          w_stk_empty;
   logic [AW-1:0] w_stk_top;

   // Stack only moves on the edge that actually advances the CAR
   useq_ret_stack #(
      .AW    (AW),
      .DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (w_advance & w_push_req),
      .pop       (w_advance & w_pop_req),
      .push_data (w_car_inc),
      .top       (w_stk_top),
      .full      (w_stk_full),
      .empty     (w_stk_empty)
   );

   // Advance target: call overrides the select field; RET pops or recovers
   always_comb begin
      w_adv_addr = ctl_next;
      w_adv_err  = 1'b0;
      w_push_req = 1'b0;
      w_pop_req  = 1'b0;
      if (ctl_call) begin
         w_adv_addr = ctl_next;
         w_push_req = 1'b1;
         w_adv_err  = w_stk_full;
      end else begin
         case (ctl_sel)
            SEL_NEXT: w_adv_addr = ctl_next;
            SEL_MAP:  w_adv_addr = map_addr;
            SEL_BRZ:  w_adv_addr = z_flag ? ctl_next : w_car_inc;
            SEL_RET: begin
               if (w_stk_empty) begin
                  w_adv_addr = FETCH_ADDR;
                  w_adv_err  = 1'b1;
               end else begin
                  w_adv_addr = w_stk_top;
                  w_pop_req  = 1'b1;
               end
            end
            default:  w_adv_addr = ctl_next;
         endcase
      end
   end
`else
   // Without a stack the call bit and depth have no function
   logic unused_cfg;
   assign unused_cfg = ctl_call ^ (STACK_DEPTH > 0);

   // Advance target: RET degrades to NEXT, errors cannot occur
   always_comb begin
      w_adv_addr = ctl_next;
      w_adv_err  = 1'b0;
      case (ctl_sel)
         SEL_NEXT: w_adv_addr = ctl_next;
         SEL_MAP:  w_adv_addr = map_addr;
         SEL_BRZ:  w_adv_addr = z_flag ? ctl_next : w_car_inc;
         SEL_RET:  w_adv_addr = ctl_next;
         default:  w_adv_addr = ctl_next;
      endcase
   end
`endif

   // Next-state and next-output decode; halt beats memory beats advance
   always_comb begin
      w_state_next   = r_state;
      w_car_next     = r_car;
      w_mem_req_next = r_mem_req;
      w_err_next     = r_err;
      w_advance      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_car_next   = FETCH_ADDR;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ctl_halt) begin
               w_state_next = ST_HALT;
            end else if (ctl_mem) begin
               w_mem_req_next = 1'b1;
               w_state_next   = ST_WAIT;
            end else begin
               w_advance = 1'b1;
            end
         end
         ST_WAIT: begin
            if (mem_ack) begin
               w_mem_req_next = 1'b0;
               w_advance      = 1'b1;
               w_state_next   = ST_RUN;
            end
         end
         ST_HALT: begin
            if (start) begin
               w_car_next   = FETCH_ADDR;
               w_err_next   = 1'b0;
               w_state_next = ST_RUN;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      if (w_advance) begin
         w_car_next = w_adv_addr;
         if (w_adv_err) begin
            w_err_next = 1'b1;
         end
      end
   end

   // State and output registers, async reset drops any pending request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_car     <= START_ADDR;
         r_mem_req <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_car     <= w_car_next;
         r_mem_req <= w_mem_req_next;
         r_err     <= w_err_next;
      end
   end

   assign car      = r_car;
   assign mem_req  = r_mem_req;
   assign state    = r_state;
   assign busy     = (r_state == ST_RUN) || (r_state == ST_WAIT);
   assign useq_err = r_err;

endmodule : micro_sequencer
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_micro_sequencer
// Description : Directed bench for micro_sequencer with a behavioural model
//               checked every cycle plus hand-computed literal expectations.
//               Stack scenarios are active when USEQ_CALL_STACK_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_micro_sequencer;

   localparam int FETCH = 1;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       z_flag = 1'b0;
   logic [4:0] map_addr = '0;
   logic [4:0] ctl_next = '0;
   logic [1:0] ctl_sel = '0;
   logic       ctl_call = 1'b0;
   logic       ctl_mem = 1'b0;
   logic       ctl_halt = 1'b0;
   logic       mem_ack = 1'b0;
   logic [4:0] car;
   logic       mem_req;
   logic       busy;
   logic [1:0] state;
   logic       useq_err;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   // Model: 0 IDLE, 1 RUN, 2 WAIT, 3 HALT
   int m_car = 0;
   int m_state = 0;
   int m_req = 0;
   int m_err = 0;
   int m_stk[$];

   micro_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .z_flag   (z_flag),
      .map_addr (map_addr),
      .ctl_next (ctl_next),
      .ctl_sel  (ctl_sel),
      .ctl_call (ctl_call),
      .ctl_mem  (ctl_mem),
      .ctl_halt (ctl_halt),
      .mem_ack  (mem_ack),
      .car      (car),
      .mem_req  (mem_req),
      .busy     (busy),
      .state    (state),
      .useq_err (useq_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Where the microprogram goes when it is allowed to move on
   task automatic model_advance();
      int inc;
      inc = (m_car + 1) % 32;
`ifdef USEQ_CALL_STACK_EN
      if (ctl_call) begin
         if (m_stk.size() < DEPTH) m_stk.push_back(inc);
         else m_err = 1;
         m_car = ctl_next;
         return;
      end
      if (ctl_sel == 2'd3) begin
         if (m_stk.size() == 0) begin
            m_car = FETCH;
            m_err = 1;
         end else begin
            m_car = m_stk.pop_back();
         end
         return;
      end
`endif
      case (ctl_sel)
         2'd1:    m_car = map_addr;
         2'd2:    m_car = z_flag ? int'(ctl_next) : inc;
         default: m_car = ctl_next;
      endcase
   endtask

   task automatic model_step();
      case (m_state)
         0: if (start) begin m_car = FETCH; m_state = 1; end
         1: begin
            if (ctl_halt) m_state = 3;
            else if (ctl_mem) begin m_req = 1; m_state = 2; end
            else model_advance();
         end
         2: if (mem_ack) begin m_req = 0; m_state = 1; model_advance(); end
         default: if (start) begin m_car = FETCH; m_err = 0; m_state = 1; end
      endcase
   endtask

   // Model tracks every edge and every reset assertion
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_car = 0; m_state = 0; m_req = 0; m_err = 0; m_stk.delete();
         end else begin
            model_step();
         end
      end
   end

   // Cycle compare, sampled just after the active edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (checking) begin
            checks++;
            if (car != m_car[4:0] || state != m_state[1:0] || mem_req != m_req[0] ||
                useq_err != m_err[0] || busy != (m_state == 1 || m_state == 2)) begin
               errors++;
               $display("FAIL cycle t=%0t: car=%0d state=%0d req=%0d err=%0d busy=%0d expected car=%0d state=%0d req=%0d err=%0d",
                        $time, car, state, mem_req, useq_err, busy, m_car, m_state, m_req, m_err);
            end
         end
      end
   end

   // Drive one cycle worth of inputs, return on the following falling edge
   task automatic go(input bit st, input int sel, input int nxt, input int map, input bit z,
                     input bit call, input bit mem, input bit halt, input bit ack);
      start = st; ctl_sel = 2'(sel); ctl_next = 5'(nxt); map_addr = 5'(map); z_flag = z;
      ctl_call = call; ctl_mem = mem; ctl_halt = halt; mem_ack = ack;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checking = 1'b1;
      go(0, 0, 0, 0, 0, 0, 0, 0, 1);          // ack while IDLE is ignored
      chk("reset_car", car, 0);
      chk("reset_state", state, 0);
      chk("reset_busy", busy, 0);
      chk("reset_req", mem_req, 0);
      chk("reset_err", useq_err, 0);

      go(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("start_car", car, 1);
      chk("start_state", state, 1);
      chk("start_busy", busy, 1);
      chk("start_req", mem_req, 0);

      go(0, 1, 0, 9, 0, 0, 0, 0, 0);
      chk("map_car", car, 9);
      go(0, 2, 11, 0, 0, 0, 0, 0, 0);
      chk("brz_z0_car", car, 10);
      go(0, 2, 11, 0, 1, 0, 0, 0, 0);
      chk("brz_z1_car", car, 11);
      go(0, 0, 4, 0, 0, 0, 0, 0, 0);
      chk("next_car", car, 4);

      // Memory access with ack on the third WAIT cycle
      go(0, 0, 5, 0, 0, 0, 1, 0, 0);
      chk("wait1_req", mem_req, 1);
      chk("wait1_state", state, 2);
      go(0, 0, 5, 0, 0, 0, 1, 0, 0);
      chk("wait2_car", car, 4);
      go(0, 0, 5, 0, 0, 0, 1, 0, 0);
      chk("wait3_req", mem_req, 1);
      go(0, 0, 5, 0, 0, 0, 1, 0, 1);
      chk("ack_car", car, 5);
      chk("ack_req", mem_req, 0);
      chk("ack_state", state, 1);
      go(0, 0, 20, 0, 0, 0, 0, 0, 1);         // ack in RUN is ignored
      chk("run_ack_car", car, 20);
      chk("run_ack_req", mem_req, 0);

      // Halt and hold
      go(0, 0, 7, 0, 0, 0, 0, 1, 0);
      chk("halt_state", state, 3);
      chk("halt_busy", busy, 0);
      for (int i = 0; i < 10; i++) go(0, 0, 7, 0, 0, 0, 0, 0, 1);
      chk("halt_hold_car", car, 20);
      go(1, 0, 31, 0, 0, 0, 0, 0, 0);
      chk("restart_car", car, 1);
      chk("restart_state", state, 1);
      go(1, 0, 31, 0, 0, 0, 0, 0, 0);         // start in RUN is ignored
      chk("start_in_run_car", car, 31);
      go(0, 2, 2, 0, 0, 0, 0, 0, 0);
      chk("wrap_car", car, 0);

`ifdef USEQ_CALL_STACK_EN
      go(0, 0, 10, 0, 0, 1, 0, 0, 0);
      go(0, 0, 12, 0, 0, 1, 0, 0, 0);
      go(0, 0, 14, 0, 0, 1, 0, 0, 0);
      go(0, 0, 16, 0, 0, 1, 0, 0, 0);
      chk("call4_err", useq_err, 0);
      go(0, 0, 18, 0, 0, 1, 0, 0, 0);
      chk("call5_car", car, 18);
      chk("call5_err", useq_err, 1);
      go(0, 3, 0, 0, 0, 0, 0, 0, 0);
      chk("ret1_car", car, 15);
      go(0, 3, 0, 0, 0, 0, 0, 0, 0);
      chk("ret2_car", car, 13);
      go(0, 3, 0, 0, 0, 0, 0, 0, 0);
      chk("ret3_car", car, 11);
      go(0, 3, 0, 0, 0, 0, 0, 0, 0);
      chk("ret4_car", car, 1);
      go(0, 3, 25, 0, 0, 0, 0, 0, 0);
      chk("ret_empty_car", car, 1);
      go(0, 3, 9, 0, 0, 1, 0, 0, 0);          // call wins over RET
      chk("call_ret_car", car, 9);
      go(0, 3, 0, 0, 0, 0, 0, 0, 0);
      chk("call_ret_pop", car, 2);
      go(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("halt_err_kept", useq_err, 1);
      go(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("start_clears_err", useq_err, 0);
`else
      go(0, 1, 6, 3, 0, 1, 0, 0, 0);
      chk("call_ignored_car", car, 3);
      go(0, 3, 12, 0, 0, 0, 0, 0, 0);
      chk("ret_as_next_car", car, 12);
      chk("err_tied", useq_err, 0);
`endif

      // Asynchronous reset in the middle of a WAIT
      go(0, 0, 8, 0, 0, 0, 0, 0, 0);
      go(0, 0, 9, 0, 0, 0, 1, 0, 0);
      chk("pre_rst_req", mem_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_req", mem_req, 0);
      chk("async_rst_car", car, 0);
      chk("async_rst_state", state, 0);
      @(negedge clk);
      rst = 1'b0;
      go(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("post_rst_start_car", car, 1);
      go(0, 0, 0, 0, 0, 0, 0, 0, 0);

      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_micro_sequencer
`default_nettype wire

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the per-core control unit. It owns the control address register (CAR), selects the next micro-address from the control-store next-address field, the opcode map, a Z-conditional branch or a micro-return, and stalls the microprogram on a memory req/ack handshake. It sits between the control store (addressed by `car`) and the core's memory port, and replaces free-running next-address selection with a clocked, handshaked sequencer.

## Interface
- `AW`, 5, micro-address width
- `START_ADDR`, 5'd0, CAR value in IDLE and after reset
- `FETCH_ADDR`, 5'd1, first micro-address of the fetch routine
- `STACK_DEPTH`, 4, micro-return stack entries (used only with `USEQ_CALL_STACK_EN`)
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  leave IDLE/HALT, begin at FETCH_ADDR
- `z_flag`  in  1  ALU zero flag, sampled at the decision edge
- `map_addr`  in  AW  mapped opcode address from MAP
- `ctl_next`  in  AW  next-address field of current microinstruction
- `ctl_sel`  in  2  00 NEXT, 01 MAP, 10 BRZ, 11 RET
- `ctl_call`  in  1  call: push return address, jump to `ctl_next`
- `ctl_mem`  in  1  current microinstruction needs memory
- `ctl_halt`  in  1  current microinstruction halts the core
- `mem_ack`  in  1  memory completion, one-cycle pulse
- `car`  out  AW  control address register (control-store address)
- `mem_req`  out  1  memory request, level, held until ack
- `busy`  out  1  high in RUN and WAIT
- `state`  out  2  00 IDLE, 01 RUN, 10 WAIT, 11 HALT
- `useq_err`  out  1  sticky stack overflow/underflow flag

## Operation
- Next-address rule (the "advance"): NEXT -> `ctl_next`; MAP -> `map_addr`; BRZ -> `z_flag ? ctl_next : car+1`; RET -> pop. `ctl_call` overrides `ctl_sel`: push `car+1`, CAR <= `ctl_next`.
- `car+1` is AW-bit, wraps modulo 2^AW (31 -> 0).
- IDLE: CAR = START_ADDR. `start` -> CAR <= FETCH_ADDR, RUN.
- RUN, priority `ctl_halt` > `ctl_mem` > advance:
  - `ctl_halt`: CAR holds, -> HALT.
  - `ctl_mem`: CAR holds, `mem_req` <= 1, -> WAIT.
  - else advance, stay RUN.
- WAIT: `mem_req` stays 1; CAR and stack frozen. On `mem_ack`: `mem_req` <= 0, advance using the current (stable) control fields and `z_flag`, -> RUN. `mem_ack` outside WAIT is ignored.
- HALT: CAR holds; `start` -> CAR <= FETCH_ADDR, clear `useq_err`, -> RUN.
- `start` in RUN/WAIT is ignored.
- Reset values: `car`=START_ADDR, `mem_req`=0, `busy`=0, `state`=IDLE, `useq_err`=0, stack pointer 0. Reset mid-WAIT drops `mem_req` immediately (async).

## Timing
- All state changes on rising `clk`; outputs registered.
- Non-memory microinstruction: 1 cycle per CAR step.
- Memory microinstruction: `mem_req` rises the edge after decode; CAR advances on the edge that samples `mem_ack`; minimum 2 cycles (ack on first WAIT cycle).
- `mem_req` deasserts on the same edge as the advance; no request re-issue without a new `ctl_mem`.
- `start` to first FETCH_ADDR on `car`: 1 edge.

## Configuration
- `USEQ_CALL_STACK_EN` defined: STACK_DEPTH-entry LIFO of AW-bit return addresses. Push on full: ignored, `useq_err` <= 1, jump still taken. RET on empty: CAR <= FETCH_ADDR, `useq_err` <= 1. Simultaneous call+RET: call wins.
- Not defined: no stack; `ctl_call` ignored; RET behaves as NEXT; `useq_err` tied 0.

## Structure
- Shared package: state encoding constants, `ctl_sel` codes, AW default, START/FETCH defaults.
- One sub-module: `useq_ret_stack` (LIFO, push/pop/full/empty), instantiated only under the macro.

## Test plan
- Reset then `start`: `car` 0 -> 1, `state` 00 -> 01, `busy` 1, `mem_req` 0.
- RUN with MAP, `map_addr`=9 -> `car`=9 next edge; BRZ `ctl_next`=11, `z_flag`=1 -> 11; `z_flag`=0 at car=9 -> 10.
- `ctl_mem` at car=4, ack after 3 WAIT cycles -> `mem_req` high 3 cycles, `car` holds 4, then `ctl_next`=5; ack in RUN ignored.
- `ctl_halt` at car=20 -> HALT, car 20 held 10 cycles; `start` -> car 1, RUN; car=31 with BRZ Z=0 -> 0.
- Macro on: 5 nested calls, depth 4 -> 5th sets `useq_err`; 4 RETs return 4 addresses in LIFO order; extra RET -> car 1.
- Async `rst` mid-WAIT -> `mem_req` 0, `car` 0, `state` IDLE before next edge.
